// File: rtl/switch_debounce_sync.sv
// Slide-switch conditioner: 2-flop synchroniser plus per-bit debounce counter.
// Optional per-bit edge pulses (sw_rise/sw_fall) are built only when SW_EDGE_EN is defined.
module switch_debounce_sync #(
    parameter int N_SW            = 5,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_SW-1:0] sw_raw,
    output logic [N_SW-1:0] sw_clean,
    output logic            sw_changed,
    output logic            sw_stable
`ifdef SW_EDGE_EN
    ,
    output logic [N_SW-1:0] sw_rise,
    output logic [N_SW-1:0] sw_fall
`endif
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_SW-1:0]  sync1_q;
    logic [N_SW-1:0]  sync2_q;
    logic [N_SW-1:0]  clean_q;
    logic [N_SW-1:0]  clean_d;
    logic             changed_q;
    logic             stable_q;
    logic [CNT_W-1:0] cnt_q [N_SW];
    logic [CNT_W-1:0] cnt_d [N_SW];
    logic [N_SW-1:0]  diff;
    logic [N_SW-1:0]  hit;
    logic [N_SW-1:0]  idle_d;

    // Only sync2 is ever compared against the clean level; sync1 just absorbs metastability.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sw_raw;
            sync2_q <= sync1_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_SW; gi++) begin : g_bit
            assign diff[gi]   = sync2_q[gi] ^ clean_q[gi];
            assign hit[gi]    = diff[gi] && (cnt_q[gi] == CNT_MAX);
            // A return to the old level or an accepted change both restart the interval.
            assign cnt_d[gi]  = (!diff[gi] || hit[gi]) ? '0 : cnt_q[gi] + CNT_W'(1);
            assign idle_d[gi] = (cnt_d[gi] == '0);

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q[gi] <= '0;
                end else begin
                    cnt_q[gi] <= cnt_d[gi];
                end
            end
        end
    endgenerate

    assign clean_d = clean_q ^ hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            clean_q   <= '0;
            changed_q <= 1'b0;
            stable_q  <= 1'b1;
        end else begin
            clean_q   <= clean_d;
            changed_q <= |hit;
            stable_q  <= &idle_d;
        end
    end

    assign sw_clean   = clean_q;
    assign sw_changed = changed_q;
    assign sw_stable  = stable_q;

`ifdef SW_EDGE_EN
    logic [N_SW-1:0] rise_q;
    logic [N_SW-1:0] fall_q;

    // An accepted bit takes the sync2 level, so that level gives the edge direction.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= hit & sync2_q;
            fall_q <= hit & ~sync2_q;
        end
    end

    assign sw_rise = rise_q;
    assign sw_fall = fall_q;
`endif

endmodule
